// File: rtl/ffstdp_pkg.sv
// Shared types and helpers for the multi-lane FF-STDP update pipeline.
// The LFSR seed and taps are only used when FFSTDP_STOCHASTIC_ROUND_EN is defined.
package ffstdp_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD        = 2'b00,
    MODE_ACCUM       = 2'b01,
    MODE_APPLY       = 2'b10,
    MODE_ACCUM_APPLY = 2'b11
  } mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps at positions 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Clamp a full-precision signed value into a signed field of 'width' bits.
  function automatic logic [31:0] sat(input logic signed [31:0] x, input int unsigned width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi)      sat = hi;
    else if (x < lo) sat = lo;
    else             sat = x;
  endfunction

  function automatic logic sat_hit(input logic signed [31:0] x, input int unsigned width);
    return sat(x, width) != x;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ffstdp_update_lanes_lane.sv
// One synapse lane: S2 derivative/delta and S3 accumulate/apply with saturation.
// FFSTDP_STOCHASTIC_ROUND_EN adds a per-lane LFSR for stochastic rounding of the delta.
module ffstdp_lane_datapath
  import ffstdp_pkg::*;
#(
`ifdef FFSTDP_STOCHASTIC_ROUND_EN
  parameter logic [15:0] SEED         = LFSR_SEED,
`endif
  parameter int unsigned C_WIDTH      = 4,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned GRAD_WIDTH   = 12,
  parameter int unsigned GOOD_FRAC    = 15,
  parameter int unsigned LR_SHIFT     = 4,
  parameter int unsigned APPLY_SHIFT  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [1:0]              i_mode,
  input  logic                    i_is_pos,
  input  logic [15:0]             i_good,
  input  logic [C_WIDTH-1:0]      i_c,
  input  logic [WEIGHT_WIDTH-1:0] i_w,
  input  logic [GRAD_WIDTH-1:0]   i_g,
  output logic [WEIGHT_WIDTH-1:0] o_w_new,
  output logic [GRAD_WIDTH-1:0]   o_g_new,
  output logic                    o_sat
);

  localparam int unsigned SH  = GOOD_FRAC + LR_SHIFT;
  localparam logic [31:0] ONE = 32'd1 << GOOD_FRAC;

  logic [31:0]        w_gterm;
  logic [31:0]        w_prod;
  logic [31:0]        w_mag;
  logic signed [31:0] w_delta;

  mode_e                   r2_mode;
  logic signed [31:0]      r2_delta;
  logic [WEIGHT_WIDTH-1:0] r2_w;
  logic [GRAD_WIDTH-1:0]   r2_g;

`ifdef FFSTDP_STOCHASTIC_ROUND_EN
  localparam logic [31:0] RND_MASK = (32'd1 << SH) - 32'd1;
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_lfsr <= SEED;
    else if (i_en) r_lfsr <= lfsr_next(r_lfsr);
  end
`endif

  always_comb begin
    w_gterm = '0;
    if (i_is_pos)                   w_gterm = {16'b0, i_good};
    else if ({16'b0, i_good} < ONE) w_gterm = ONE - {16'b0, i_good};
    w_prod = 32'(i_c) * w_gterm;
    w_mag  = w_prod >> SH;
`ifdef FFSTDP_STOCHASTIC_ROUND_EN
    if (({16'b0, r_lfsr} & RND_MASK) < (w_prod & RND_MASK)) w_mag = w_mag + 32'd1;
`endif
    w_delta = i_is_pos ? $signed(w_mag) : -$signed(w_mag);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r2_mode  <= MODE_HOLD;
      r2_delta <= '0;
      r2_w     <= '0;
      r2_g     <= '0;
    end else if (i_en) begin
      r2_mode  <= mode_e'(i_mode);
      r2_delta <= w_delta;
      r2_w     <= i_w;
      r2_g     <= i_g;
    end
  end

  logic signed [31:0]      w_w32;
  logic signed [31:0]      w_g32;
  logic signed [31:0]      w_gsum;
  logic [GRAD_WIDTH-1:0]   w_gacc;
  logic                    w_gacc_hit;
  logic signed [31:0]      w_gacc32;
  logic signed [31:0]      w_wsum;
  logic [WEIGHT_WIDTH-1:0] w_wsat;
  logic                    w_wsat_hit;
  logic [WEIGHT_WIDTH-1:0] w3_w;
  logic [GRAD_WIDTH-1:0]   w3_g;
  logic                    w3_hit;

  // APPLY adds the incoming gradient; ACCUM_APPLY adds the freshly saturated accumulator.
  always_comb begin
    w_w32      = {{(32 - WEIGHT_WIDTH){r2_w[WEIGHT_WIDTH-1]}}, r2_w};
    w_g32      = {{(32 - GRAD_WIDTH){r2_g[GRAD_WIDTH-1]}}, r2_g};
    w_gsum     = w_g32 + r2_delta;
    w_gacc     = GRAD_WIDTH'(sat(w_gsum, GRAD_WIDTH));
    w_gacc_hit = sat_hit(w_gsum, GRAD_WIDTH);
    w_gacc32   = {{(32 - GRAD_WIDTH){w_gacc[GRAD_WIDTH-1]}}, w_gacc};
    w_wsum     = w_w32 + (((r2_mode == MODE_APPLY) ? w_g32 : w_gacc32) >>> APPLY_SHIFT);
    w_wsat     = WEIGHT_WIDTH'(sat(w_wsum, WEIGHT_WIDTH));
    w_wsat_hit = sat_hit(w_wsum, WEIGHT_WIDTH);
    w3_w   = r2_w;
    w3_g   = r2_g;
    w3_hit = 1'b0;
    case (r2_mode)
      MODE_HOLD: ;
      MODE_ACCUM: begin
        w3_g   = w_gacc;
        w3_hit = w_gacc_hit;
      end
      MODE_APPLY: begin
        w3_w   = w_wsat;
        w3_g   = '0;
        w3_hit = w_wsat_hit;
      end
      MODE_ACCUM_APPLY: begin
        w3_w   = w_wsat;
        w3_g   = '0;
        w3_hit = w_gacc_hit | w_wsat_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_w_new <= '0;
      o_g_new <= '0;
      o_sat   <= 1'b0;
    end else if (i_en) begin
      o_w_new <= w3_w;
      o_g_new <= w3_g;
      o_sat   <= w3_hit;
    end
  end

endmodule

// File: rtl/ffstdp_update_lanes.sv
// Multi-lane FF-STDP update pipeline: handshake, valid pipe, address sideband, SAT_CNT.
// Optional FFSTDP_STOCHASTIC_ROUND_EN enables stochastic rounding inside each lane.
module ffstdp_update_lanes
  import ffstdp_pkg::*;
#(
  parameter int unsigned N_LANES      = 4,
  parameter int unsigned SPK_WIDTH    = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned GRAD_WIDTH   = 12,
  parameter int unsigned GOOD_FRAC    = 15,
  parameter int unsigned LR_SHIFT     = 4,
  parameter int unsigned APPLY_SHIFT  = 2,
  parameter int unsigned ADDR_WIDTH   = 10
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [1:0]                      IN_MODE,
  input  logic                            IN_IS_POS,
  input  logic [ADDR_WIDTH-1:0]           IN_ADDR,
  input  logic [15:0]                     AVG_GOODNESS,
  input  logic [N_LANES*SPK_WIDTH-1:0]    PRE_SPIKE_VEC,
  input  logic [N_LANES*SPK_WIDTH-1:0]    POST_SPIKE_VEC,
  input  logic [N_LANES*WEIGHT_WIDTH-1:0] WSYN_CURR,
  input  logic [N_LANES*GRAD_WIDTH-1:0]   GRAD_CURR,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [ADDR_WIDTH-1:0]           OUT_ADDR,
  output logic [N_LANES*WEIGHT_WIDTH-1:0] WSYN_NEW,
  output logic [N_LANES*GRAD_WIDTH-1:0]   GRAD_NEW,
  output logic [15:0]                     SAT_CNT
);

  localparam int unsigned C_WIDTH = $clog2(SPK_WIDTH + 1);

  logic w_en;
  logic r_v1, r_v2, r_v3;
  logic [1:0]                      r1_mode;
  logic                            r1_pos;
  logic [15:0]                     r1_good;
  logic [ADDR_WIDTH-1:0]           r1_addr, r2_addr, r3_addr;
  logic [N_LANES*WEIGHT_WIDTH-1:0] r1_w;
  logic [N_LANES*GRAD_WIDTH-1:0]   r1_g;
  logic [C_WIDTH-1:0]              w_c  [N_LANES];
  logic [C_WIDTH-1:0]              r1_c [N_LANES];
  logic [N_LANES-1:0]              w_lane_sat;
  logic [15:0]                     r_sat_cnt;
  logic [15:0]                     w_nsat;
  logic [16:0]                     w_sat_sum;

  assign w_en      = !r_v3 || OUT_READY;
  assign IN_READY  = w_en;
  assign OUT_VALID = r_v3;
  assign OUT_ADDR  = r3_addr;
  assign SAT_CNT   = r_sat_cnt;

  for (genvar l = 0; l < N_LANES; l++) begin : g_pop
    assign w_c[l] = C_WIDTH'($countones(PRE_SPIKE_VEC[l*SPK_WIDTH +: SPK_WIDTH] &
                                        POST_SPIKE_VEC[l*SPK_WIDTH +: SPK_WIDTH]));
  end

  // Bubbles advance too, so every stage moves in lock-step with w_en.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r1_mode <= '0;
      r1_pos  <= 1'b0;
      r1_good <= '0;
      r1_addr <= '0;
      r2_addr <= '0;
      r3_addr <= '0;
      r1_w    <= '0;
      r1_g    <= '0;
      for (int unsigned l = 0; l < N_LANES; l++) r1_c[l] <= '0;
    end else if (w_en) begin
      r_v1    <= IN_VALID;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      r1_mode <= IN_MODE;
      r1_pos  <= IN_IS_POS;
      r1_good <= AVG_GOODNESS;
      r1_addr <= IN_ADDR;
      r2_addr <= r1_addr;
      r3_addr <= r2_addr;
      r1_w    <= WSYN_CURR;
      r1_g    <= GRAD_CURR;
      for (int unsigned l = 0; l < N_LANES; l++) r1_c[l] <= w_c[l];
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    ffstdp_lane_datapath #(
`ifdef FFSTDP_STOCHASTIC_ROUND_EN
      .SEED         (LFSR_SEED + 16'(l)),
`endif
      .C_WIDTH      (C_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .GRAD_WIDTH   (GRAD_WIDTH),
      .GOOD_FRAC    (GOOD_FRAC),
      .LR_SHIFT     (LR_SHIFT),
      .APPLY_SHIFT  (APPLY_SHIFT)
    ) u_lane (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_en     (w_en),
      .i_mode   (r1_mode),
      .i_is_pos (r1_pos),
      .i_good   (r1_good),
      .i_c      (r1_c[l]),
      .i_w      (r1_w[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .i_g      (r1_g[l*GRAD_WIDTH +: GRAD_WIDTH]),
      .o_w_new  (WSYN_NEW[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .o_g_new  (GRAD_NEW[l*GRAD_WIDTH +: GRAD_WIDTH]),
      .o_sat    (w_lane_sat[l])
    );
  end

  always_comb begin
    w_nsat = '0;
    for (int unsigned l = 0; l < N_LANES; l++) w_nsat = w_nsat + 16'(w_lane_sat[l]);
    w_sat_sum = {1'b0, r_sat_cnt} + {1'b0, w_nsat};
  end

  always_ff @(posedge CLK) begin
    if (RST)                        r_sat_cnt <= '0;
    else if (r_v3 && OUT_READY)     r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
  end

endmodule
